// File: rtl/rob_commit_ctrl_pkg.sv
// rtl/rob_commit_ctrl_pkg.sv - shared type and constant definitions for the reorder buffer
package rob_commit_ctrl_pkg;

    localparam int ROB_ID_W_DEF = 5;
    localparam int DATA_W       = 32;
    localparam int REG_POS_W    = 5;

    typedef logic [ROB_ID_W_DEF-1:0] ROB_ID_TYPE;
    typedef logic [DATA_W-1:0]       DATA_TYPE;
    typedef logic [REG_POS_W-1:0]    REG_POS_TYPE;

    // Tag 0 is reserved to mean "operand has no pending producer"
    localparam ROB_ID_TYPE  ZERO_ROB  = '0;
    localparam REG_POS_TYPE ZERO_REG  = '0;
    localparam DATA_TYPE    ZERO_WORD = '0;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

endpackage

// File: rtl/rob_commit_ctrl.sv
// rtl/rob_commit_ctrl.sv - in-order reorder buffer commit control; optional same-edge CDB bypass via ROB_CDB_BYPASS_EN
module rob_commit_ctrl
    import rob_commit_ctrl_pkg::*;
#(
    parameter int ROB_SIZE = 16,
    parameter int ROB_ID_W = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                alloc_flag_from_dsp,
    input  logic [4:0]          alloc_rd_from_dsp,
    output logic                full_to_dsp,
    output logic [ROB_ID_W-1:0] alloc_Q_to_dsp,
    input  logic                cdb_flag,
    input  logic [ROB_ID_W-1:0] cdb_Q,
    input  logic [31:0]         cdb_V,
    input  logic                cdb_mispredict,
    input  logic [ROB_ID_W-1:0] query_Q_from_dsp,
    output logic                query_ready_to_dsp,
    output logic [31:0]         query_V_to_dsp,
    output logic                commit_flag_to_reg,
    output logic [4:0]          rd_to_reg,
    output logic [ROB_ID_W-1:0] Q_to_reg,
    output logic [31:0]         V_to_reg,
    output logic                rollback_flag_to_reg
);

    localparam int IDX_W = $clog2(ROB_SIZE);
    localparam int CNT_W = $clog2(ROB_SIZE + 1);
    localparam logic [ROB_ID_W-1:0] NO_TAG  = ROB_ID_W'(ZERO_ROB);
    localparam logic [ROB_ID_W-1:0] ONE_TAG = ROB_ID_W'(1);
    localparam logic [ROB_ID_W-1:0] MAX_TAG = ROB_ID_W'(ROB_SIZE);

    // Per-entry state; the tag of entry i is i+1
    logic [ROB_SIZE-1:0] busy_q;
    logic [ROB_SIZE-1:0] ready_q;
    logic [ROB_SIZE-1:0] mispred_q;
    REG_POS_TYPE         rd_q    [ROB_SIZE];
    DATA_TYPE            value_q [ROB_SIZE];

    logic [IDX_W-1:0] head_q;
    logic [IDX_W-1:0] tail_q;
    logic [CNT_W-1:0] count_q;

    logic             cdb_in_range;
    logic [IDX_W-1:0] cdb_idx;
    logic             cdb_hit;
    logic             query_in_range;
    logic [IDX_W-1:0] query_idx;
    logic             commit_en;
    logic             commit_mp;
    DATA_TYPE         commit_v;
    logic             rollback_en;
    logic             alloc_en;

    // Tags outside 1..ROB_SIZE never address an entry
    assign cdb_in_range   = (cdb_Q != NO_TAG) && (cdb_Q <= MAX_TAG);
    assign cdb_idx        = IDX_W'(cdb_Q - ONE_TAG);
    assign cdb_hit        = cdb_flag && cdb_in_range && busy_q[cdb_idx];

    assign query_in_range = (query_Q_from_dsp != NO_TAG) && (query_Q_from_dsp <= MAX_TAG);
    assign query_idx      = IDX_W'(query_Q_from_dsp - ONE_TAG);

    assign full_to_dsp    = (count_q == CNT_W'(ROB_SIZE));
    assign alloc_Q_to_dsp = ROB_ID_W'(tail_q) + ONE_TAG;

    // Operand lookup straight from stored state; idle entries read as not ready, zero
    always_comb begin
        query_ready_to_dsp = FALSE;
        query_V_to_dsp     = ZERO_WORD;
        if (query_in_range && busy_q[query_idx]) begin
            query_ready_to_dsp = ready_q[query_idx];
            query_V_to_dsp     = value_q[query_idx];
        end
    end

    // Decide whether the head retires this edge and with which result
    always_comb begin
        commit_en = FALSE;
        commit_mp = FALSE;
        commit_v  = ZERO_WORD;
        if (busy_q[head_q] && ready_q[head_q]) begin
            commit_en = TRUE;
            commit_mp = mispred_q[head_q];
            commit_v  = value_q[head_q];
        end
`ifdef ROB_CDB_BYPASS_EN
        else if (cdb_hit && (cdb_idx == head_q)) begin
            commit_en = TRUE;
            commit_mp = cdb_mispredict;
            commit_v  = cdb_V;
        end
`endif
        rollback_en = commit_en && commit_mp;
        // A flush wins over a same-cycle allocation
        alloc_en    = alloc_flag_from_dsp && !full_to_dsp && !rollback_en;
    end

    // Entry array and pointer maintenance; commit clear is ordered after the CDB write
    always_ff @(posedge clk) begin
        if (rst || rollback_en) begin
            busy_q    <= '0;
            ready_q   <= '0;
            mispred_q <= '0;
            for (int i = 0; i < ROB_SIZE; i++) begin
                rd_q[i]    <= ZERO_REG;
                value_q[i] <= ZERO_WORD;
            end
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (cdb_hit) begin
                ready_q[cdb_idx]   <= TRUE;
                value_q[cdb_idx]   <= cdb_V;
                mispred_q[cdb_idx] <= cdb_mispredict;
            end
            if (commit_en) begin
                busy_q[head_q]    <= FALSE;
                ready_q[head_q]   <= FALSE;
                mispred_q[head_q] <= FALSE;
                value_q[head_q]   <= ZERO_WORD;
                head_q            <= head_q + IDX_W'(1);
            end
            if (alloc_en) begin
                busy_q[tail_q]    <= TRUE;
                ready_q[tail_q]   <= FALSE;
                mispred_q[tail_q] <= FALSE;
                rd_q[tail_q]      <= alloc_rd_from_dsp;
                value_q[tail_q]   <= ZERO_WORD;
                tail_q            <= tail_q + IDX_W'(1);
            end
            count_q <= count_q + CNT_W'(alloc_en) - CNT_W'(commit_en);
        end
    end

    // Registered commit/rollback pulses; commit payload holds between commits
    always_ff @(posedge clk) begin
        if (rst) begin
            commit_flag_to_reg   <= FALSE;
            rollback_flag_to_reg <= FALSE;
            rd_to_reg            <= ZERO_REG;
            Q_to_reg             <= NO_TAG;
            V_to_reg             <= ZERO_WORD;
        end else begin
            commit_flag_to_reg   <= commit_en;
            rollback_flag_to_reg <= rollback_en;
            if (commit_en) begin
                rd_to_reg <= rd_q[head_q];
                Q_to_reg  <= ROB_ID_W'(head_q) + ONE_TAG;
                V_to_reg  <= commit_v;
            end
        end
    end

endmodule

// File: tb/tb_rob_commit_ctrl.sv
// tb/tb_rob_commit_ctrl.sv - self-checking bench for rob_commit_ctrl against an in-order queue model
module tb_rob_commit_ctrl;

    logic        clk;
    logic        rst;
    logic        alloc_flag_from_dsp;
    logic [4:0]  alloc_rd_from_dsp;
    logic        full_to_dsp;
    logic [4:0]  alloc_Q_to_dsp;
    logic        cdb_flag;
    logic [4:0]  cdb_Q;
    logic [31:0] cdb_V;
    logic        cdb_mispredict;
    logic [4:0]  query_Q_from_dsp;
    logic        query_ready_to_dsp;
    logic [31:0] query_V_to_dsp;
    logic        commit_flag_to_reg;
    logic [4:0]  rd_to_reg;
    logic [4:0]  Q_to_reg;
    logic [31:0] V_to_reg;
    logic        rollback_flag_to_reg;

    rob_commit_ctrl #(.ROB_SIZE(16), .ROB_ID_W(5)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .alloc_flag_from_dsp (alloc_flag_from_dsp),
        .alloc_rd_from_dsp   (alloc_rd_from_dsp),
        .full_to_dsp         (full_to_dsp),
        .alloc_Q_to_dsp      (alloc_Q_to_dsp),
        .cdb_flag            (cdb_flag),
        .cdb_Q               (cdb_Q),
        .cdb_V               (cdb_V),
        .cdb_mispredict      (cdb_mispredict),
        .query_Q_from_dsp    (query_Q_from_dsp),
        .query_ready_to_dsp  (query_ready_to_dsp),
        .query_V_to_dsp      (query_V_to_dsp),
        .commit_flag_to_reg  (commit_flag_to_reg),
        .rd_to_reg           (rd_to_reg),
        .Q_to_reg            (Q_to_reg),
        .V_to_reg            (V_to_reg),
        .rollback_flag_to_reg(rollback_flag_to_reg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Program-order model: queue front is the oldest in-flight instruction
    typedef struct {
        int          tag;
        logic [4:0]  rd;
        bit          rdy;
        logic [31:0] v;
        bit          mp;
    } ent_t;

    ent_t        mq[$];
    int          next_tag;
    logic        exp_flag;
    logic        exp_rb;
    logic [4:0]  exp_rd;
    logic [4:0]  exp_q;
    logic [31:0] exp_v;
    int          checks;
    int          failures;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    task automatic lookup(input int t, output bit r, output logic [31:0] v);
        r = 1'b0;
        v = '0;
        foreach (mq[i]) if (mq[i].tag == t) begin
            r = mq[i].rdy;
            v = mq[i].v;
        end
    endtask

    task automatic model_edge(input bit a, input int rdv, input bit cf, input int cq,
                              input logic [31:0] cv, input bit cm, input bit r);
        bit          do_commit;
        bit          mp;
        logic [31:0] v;
        bit          was_full;
        ent_t        e;
        if (r) begin
            mq.delete();
            next_tag = 1;
            exp_flag = 0; exp_rb = 0; exp_rd = 0; exp_q = 0; exp_v = 0;
            return;
        end
        do_commit = 0; mp = 0; v = 0;
        was_full  = (mq.size() == 16);
        if (mq.size() > 0) begin
            if (mq[0].rdy) begin
                do_commit = 1; v = mq[0].v; mp = mq[0].mp;
            end
`ifdef ROB_CDB_BYPASS_EN
            else if (cf && cq == mq[0].tag) begin
                do_commit = 1; v = cv; mp = cm;
            end
`endif
        end
        exp_flag = do_commit;
        exp_rb   = do_commit && mp;
        if (do_commit) begin
            exp_rd = mq[0].rd;
            exp_q  = 5'(mq[0].tag);
            exp_v  = v;
        end
        if (exp_rb) begin
            mq.delete();
            next_tag = 1;
        end else begin
            if (cf) foreach (mq[i]) if (mq[i].tag == cq) begin
                mq[i].rdy = 1; mq[i].v = cv; mq[i].mp = cm;
            end
            if (do_commit) void'(mq.pop_front());
            if (a && !was_full) begin
                e.tag = next_tag; e.rd = 5'(rdv); e.rdy = 0; e.v = '0; e.mp = 0;
                mq.push_back(e);
                next_tag = (next_tag == 16) ? 1 : next_tag + 1;
            end
        end
    endtask

    // One clock: drive, check combinational outputs mid-cycle, advance, check registered outputs
    task automatic step(input bit a, input int rdv, input bit cf, input int cq,
                        input logic [31:0] cv, input bit cm, input int qq, input bit r);
        bit          er;
        logic [31:0] ev;
        alloc_flag_from_dsp = a;
        alloc_rd_from_dsp   = 5'(rdv);
        cdb_flag            = cf;
        cdb_Q               = 5'(cq);
        cdb_V               = cv;
        cdb_mispredict      = cm;
        query_Q_from_dsp    = 5'(qq);
        rst                 = r;
        @(negedge clk);
        check("full", 32'(full_to_dsp), 32'(mq.size() == 16));
        check("alloc_q", 32'(alloc_Q_to_dsp), 32'(next_tag));
        lookup(qq, er, ev);
        check("query_ready", 32'(query_ready_to_dsp), 32'(er));
        check("query_v", query_V_to_dsp, ev);
        model_edge(a, rdv, cf, cq, cv, cm, r);
        @(posedge clk);
        #1;
        check("commit_flag", 32'(commit_flag_to_reg), 32'(exp_flag));
        check("rollback_flag", 32'(rollback_flag_to_reg), 32'(exp_rb));
        check("rd", 32'(rd_to_reg), 32'(exp_rd));
        check("q", 32'(Q_to_reg), 32'(exp_q));
        check("v", V_to_reg, exp_v);
    endtask

    task automatic do_reset();
        step(0, 0, 0, 0, 0, 0, 0, 1);
    endtask
    task automatic do_alloc(input int rdv);
        step(1, rdv, 0, 0, 0, 0, 0, 0);
    endtask
    task automatic do_cdb(input int t, input logic [31:0] v, input bit m);
        step(0, 0, 1, t, v, m, 0, 0);
    endtask
    task automatic do_idle(input int qq);
        step(0, 0, 0, 0, 0, 0, qq, 0);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        next_tag = 1;
        exp_flag = 0; exp_rb = 0; exp_rd = 0; exp_q = 0; exp_v = 0;

        // Reset values
        do_reset();
        do_reset();
        check("rst_commit", 32'(commit_flag_to_reg), 32'd0);
        check("rst_rollback", 32'(rollback_flag_to_reg), 32'd0);
        check("rst_full", 32'(full_to_dsp), 32'd0);
        check("rst_alloc_q", 32'(alloc_Q_to_dsp), 32'd1);
        check("rst_v", V_to_reg, 32'd0);

        // Single alloc, broadcast, commit one cycle later
        do_alloc(3);
        do_cdb(1, 32'h55, 0);
`ifndef ROB_CDB_BYPASS_EN
        check("lat_no_early_commit", 32'(commit_flag_to_reg), 32'd0);
        do_idle(0);
        check("basic_commit", 32'(commit_flag_to_reg), 32'd1);
        check("basic_rd", 32'(rd_to_reg), 32'd3);
        check("basic_q", 32'(Q_to_reg), 32'd1);
        check("basic_v", V_to_reg, 32'h55);
`endif
        do_idle(0);
        check("pulse_ends", 32'(commit_flag_to_reg), 32'd0);

        // Fill to full, overflow ignored, commit one frees an entry, tail wraps
        do_reset();
        for (int i = 0; i < 16; i++) do_alloc(i);
        check("full_at_16", 32'(full_to_dsp), 32'd1);
        check("alloc_q_wrapped", 32'(alloc_Q_to_dsp), 32'd1);
        do_alloc(31);
        do_cdb(1, 32'hC0FFEE, 0);
        do_idle(0);
        check("full_after_commit", 32'(full_to_dsp), 32'd0);
        check("alloc_q_after_commit", 32'(alloc_Q_to_dsp), 32'd1);

        // Out-of-order completion retires in order
        do_reset();
        for (int i = 0; i < 4; i++) do_alloc(i + 10);
        do_cdb(2, 32'h22, 0);
        do_cdb(1, 32'h11, 0);
        do_idle(0);
        check("ooo_first_q", 32'(Q_to_reg), 32'd1);
        do_idle(0);
        check("ooo_second_q", 32'(Q_to_reg), 32'd2);
        check("ooo_second_flag", 32'(commit_flag_to_reg), 32'd1);

        // Mispredict on tag 2 flushes the younger entries
        do_reset();
        for (int i = 0; i < 4; i++) do_alloc(i + 1);
        do_cdb(2, 32'hAA, 1);
        do_cdb(1, 32'h11, 0);
        do_idle(0);
        check("mp_first_rb", 32'(rollback_flag_to_reg), 32'd0);
        do_idle(3);
        check("mp_rb", 32'(rollback_flag_to_reg), 32'd1);
        check("mp_q", 32'(Q_to_reg), 32'd2);
        check("mp_alloc_q", 32'(alloc_Q_to_dsp), 32'd1);
        check("mp_query_flushed", 32'(query_ready_to_dsp), 32'd0);

        // Broadcast to an unallocated tag is ignored
        do_reset();
        do_alloc(1);
        do_alloc(2);
        do_cdb(7, 32'h77, 0);
        do_idle(7);
        check("unalloc_query", 32'(query_ready_to_dsp), 32'd0);
        check("unalloc_no_commit", 32'(commit_flag_to_reg), 32'd0);

        // Reset while a commit is pending aborts it
        do_reset();
        do_alloc(9);
        do_cdb(1, 32'h99, 0);
        do_reset();
        check("rst_abort_commit", 32'(commit_flag_to_reg), 32'd0);
        check("rst_abort_rd", 32'(rd_to_reg), 32'd0);
        check("rst_abort_alloc_q", 32'(alloc_Q_to_dsp), 32'd1);

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            bit a, cf, cm, r;
            int cq, qq;
            a  = ($urandom_range(0, 9) < 6);
            cf = ($urandom_range(0, 9) < 7);
            cm = ($urandom_range(0, 11) == 0);
            r  = ($urandom_range(0, 399) == 0);
            if (mq.size() > 0 && $urandom_range(0, 3) != 0)
                cq = mq[$urandom_range(0, mq.size() - 1)].tag;
            else
                cq = $urandom_range(0, 31);
            if (mq.size() > 0 && $urandom_range(0, 1) == 1)
                qq = mq[$urandom_range(0, mq.size() - 1)].tag;
            else
                qq = $urandom_range(0, 31);
            step(a, $urandom_range(0, 31), cf, cq, $urandom, cm, qq, r);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rob_commit_ctrl.md
ROB_COMMIT_CTRL -- requirements
Module: rob_commit_ctrl

Interface
REQ-001 The block SHALL have parameter ROB_SIZE, default 16, meaning number of reorder entries (power of two).
REQ-002 The block SHALL have parameter ROB_ID_W, default 5, meaning ROB tag width; tag 0 (ZERO_ROB) means "no producer".
REQ-003 The block SHALL have one clock and synchronous active-high reset, with the following ports:
- clk  in  1  sole clock, all state on posedge
- rst  in  1  synchronous, active-high reset
- alloc_flag_from_dsp  in  1  dispatcher requests an entry
- alloc_rd_from_dsp  in  5  destination register of allocated instruction
- full_to_dsp  out  1  no free entry
- alloc_Q_to_dsp  out  ROB_ID_W  tag the next allocation receives (1..ROB_SIZE)
- cdb_flag  in  1  result broadcast valid
- cdb_Q  in  ROB_ID_W  tag of broadcast result
- cdb_V  in  32  broadcast value
- cdb_mispredict  in  1  broadcast instruction is a mispredicted branch
- query_Q_from_dsp  in  ROB_ID_W  operand tag lookup
- query_ready_to_dsp  out  1  looked-up entry busy and ready
- query_V_to_dsp  out  32  looked-up entry value
- commit_flag_to_reg  out  1  one-cycle commit pulse to register file
- rd_to_reg  out  5  committed destination
- Q_to_reg  out  ROB_ID_W  committed tag
- V_to_reg  out  32  committed value
- rollback_flag_to_reg  out  1  one-cycle flush pulse

Function
REQ-004 Each entry SHALL hold busy, ready, rd, value and mispredict; tag = index+1.
REQ-005 Allocation SHALL occur when alloc_flag_from_dsp=1 and full_to_dsp=0 and no rollback is issued that cycle: entry[tail] busy=1, ready=0, tail wraps modulo ROB_SIZE.
REQ-006 Allocation while full SHALL be ignored with no state change.
REQ-007 full_to_dsp SHALL be combinational, 1 exactly when count==ROB_SIZE; alloc_Q_to_dsp SHALL equal tail+1.
REQ-008 A CDB broadcast SHALL set ready, value and mispredict of entry cdb_Q-1 on the same edge if that entry is busy; broadcasts to non-busy entries or tag 0 SHALL be ignored.
REQ-009 Query outputs SHALL be combinational from stored state; tag 0 SHALL return ready=0, V=0.
REQ-010 On each edge where head entry is busy and ready, the block SHALL register commit_flag_to_reg=1 with rd, Q=head+1, V, clear the entry and advance head; otherwise commit_flag_to_reg=0 and rd/Q/V hold.
REQ-011 Latency SHALL be: CDB at edge N, commit pulse visible after edge N+1 (one entry per cycle maximum).
REQ-012 If the committed entry has mispredict=1, rollback_flag_to_reg SHALL pulse in the same cycle as that commit, and all entries SHALL clear with head=tail=count=0.
REQ-013 Simultaneous allocation and commit SHALL leave count unchanged; simultaneous allocation and rollback SHALL drop the allocation.
REQ-014 Head and tail SHALL wrap from ROB_SIZE-1 to 0 with no lost or duplicated entry.

Reset
REQ-015 On rst=1 at a clock edge, all entries SHALL clear, head=tail=count=0, and outputs SHALL be commit_flag=0, rollback_flag=0, rd=0, Q=0, V=0, full=0, alloc_Q=1; reset mid-commit SHALL abort the pulse.

Configuration
REQ-016 With macro ROB_CDB_BYPASS_EN defined, a broadcast matching the busy head entry SHALL commit on that same edge using cdb_V/cdb_mispredict (latency 0 extra cycles); without it, REQ-011 latency SHALL apply.

Structure
REQ-017 ROB_ID_TYPE, DATA_TYPE, REG_POS_TYPE, ZERO_ROB, ZERO_REG, ZERO_WORD, TRUE/FALSE SHALL come from the shared defines file.
REQ-018 The block SHALL be a single module; no sub-module is warranted.

Verification
REQ-019 Reset, then alloc rd=3 (tag 1), CDB Q=1 V=0x55 -> next cycle commit_flag=1, rd=3, Q=1, V=0x55.
REQ-020 Allocate 16 entries -> full=1; 17th alloc ignored; commit one -> full=0, alloc_Q=1 (wrap).
REQ-021 Complete tags 2 then 1 -> commits in order tag 1, tag 2 on consecutive cycles.
REQ-022 Tag 2 broadcast with mispredict=1, tags 1-4 busy -> commit tag 1, then commit tag 2 with rollback_flag=1; count=0, alloc_Q=1.
REQ-023 CDB to unallocated tag 7 -> no state change; query_Q=7 returns ready=0.
REQ-024 rst during pending commit -> all outputs at reset values next cycle, no commit pulse.
